// File: rtl/pe_stream_responder.sv
// Round-robin responder for PE stream requests: reads filter words or input
// activations from a synchronous buffer SRAM and streams them to one PE with backpressure.
module pe_stream_responder #(
  parameter int unsigned NUM_PE    = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned LEN_W     = 10,
  parameter int unsigned NUM_LAYER = 4,
  parameter int unsigned K_W       = 4,
  parameter int unsigned L_W       = (NUM_LAYER > 1) ? $clog2(NUM_LAYER) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PE-1:0]           req_filter_valid,
  input  logic [NUM_PE*K_W-1:0]       req_filter_k,
  input  logic [NUM_PE*L_W-1:0]       req_layer,
  input  logic [NUM_PE-1:0]           req_input_valid,
  input  logic [NUM_LAYER*ADDR_W-1:0] cfg_w_base,
  input  logic [NUM_LAYER*LEN_W-1:0]  cfg_w_len,
  input  logic [ADDR_W-1:0]           cfg_in_base,
  input  logic [LEN_W-1:0]            cfg_in_len,
  output logic                        mem_rd_en,
  output logic [ADDR_W-1:0]           mem_rd_addr,
  input  logic [DATA_W-1:0]           mem_rd_data,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [NUM_PE-1:0]           out_pe_sel,
  output logic                        out_is_filter,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic [NUM_PE-1:0]           filter_finish,
  output logic [NUM_PE-1:0]           input_finish
);

  localparam int unsigned PE_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int unsigned PROD_W = K_W + LEN_W;

  typedef enum logic [2:0] {IDLE, ARB, LOAD, STREAM, DONE} state_t;

  state_t             state_q, state_d;
  logic [PE_W-1:0]    pe_q, pe_d, rr_q, rr_d;
  logic               is_filter_q, is_filter_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic [NUM_PE-1:0]  ff_q, ff_d, if_q, if_d;

  logic [NUM_PE-1:0]  pend_f, pend_i;
  logic               found, gnt_filter;
  logic [PE_W-1:0]    gnt, idx;
  logic [L_W-1:0]     layer;
  logic [K_W-1:0]     k;
  logic [ADDR_W-1:0]  w_base, f_addr;
  logic [LEN_W-1:0]   w_len;
  logic [PROD_W-1:0]  prod;
  logic               accept, active;

  assign pend_f = req_filter_valid & ~ff_q;
  assign pend_i = req_input_valid & ~if_q;
  assign accept = (state_q == STREAM) && out_ready;
  assign active = (state_q == LOAD) || (state_q == STREAM);

  // Round-robin scan from rr_q; input requests win over filter within a PE
  always_comb begin
    found      = 1'b0;
    gnt        = '0;
    gnt_filter = 1'b0;
    idx        = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      idx = PE_W'((32'(rr_q) + i) % NUM_PE);
      if (!found && (pend_i[idx] || pend_f[idx])) begin
        found      = 1'b1;
        gnt        = idx;
        gnt_filter = !pend_i[idx];
      end
    end
    layer  = req_layer[32'(gnt)*L_W +: L_W];
    k      = req_filter_k[32'(gnt)*K_W +: K_W];
    w_base = cfg_w_base[32'(layer)*ADDR_W +: ADDR_W];
    w_len  = cfg_w_len[32'(layer)*LEN_W +: LEN_W];
    prod   = PROD_W'(k) * PROD_W'(w_len);
    f_addr = w_base + ADDR_W'(prod);
  end

  // Next-state and memory/stream control
  always_comb begin
    state_d     = state_q;
    pe_d        = pe_q;
    rr_d        = rr_q;
    is_filter_d = is_filter_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    ff_d        = ff_q & req_filter_valid;
    if_d        = if_q & req_input_valid;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    case (state_q)
      IDLE: state_d = ARB;
      ARB: begin
        if (found) begin
          pe_d        = gnt;
          is_filter_d = gnt_filter;
          base_d      = gnt_filter ? f_addr : cfg_in_base;
          len_d       = gnt_filter ? w_len : cfg_in_len;
          state_d     = ((gnt_filter ? w_len : cfg_in_len) == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = base_q;
        cnt_d       = '0;
        state_d     = STREAM;
      end
      STREAM: begin
        out_valid   = 1'b1;
        mem_rd_en   = 1'b1;
        // Prefetch the next word on accept; a stall re-reads the current one
        mem_rd_addr = base_q + ADDR_W'(cnt_q) + ADDR_W'(accept);
        out_last    = (cnt_q == len_q - LEN_W'(1));
        if (accept && out_last) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + LEN_W'(accept);
        end
      end
      DONE: begin
        if (is_filter_q) ff_d[pe_q] = 1'b1;
        else             if_d[pe_q] = 1'b1;
        rr_d    = PE_W'((32'(pe_q) + 1) % NUM_PE);
        state_d = ARB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pe_q        <= '0;
      rr_q        <= '0;
      is_filter_q <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      ff_q        <= '0;
      if_q        <= '0;
    end else begin
      state_q     <= state_d;
      pe_q        <= pe_d;
      rr_q        <= rr_d;
      is_filter_q <= is_filter_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      ff_q        <= ff_d;
      if_q        <= if_d;
    end
  end

  assign out_data      = (state_q == STREAM) ? mem_rd_data : '0;
  assign out_pe_sel    = active ? (NUM_PE'(1) << pe_q) : '0;
  assign out_is_filter = active && is_filter_q;
  assign filter_finish = ff_q;
  assign input_finish  = if_q;

endmodule

// File: tb/tb_pe_stream_responder.sv
// Self-checking bench for pe_stream_responder: table-driven transfers plus
// hand sequences, with a beat scoreboard fed at request time.
module tb_pe_stream_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_filter_valid = '0;
  logic [15:0] req_filter_k = '0;
  logic [7:0]  req_layer = '0;
  logic [3:0]  req_input_valid = '0;
  logic [47:0] cfg_w_base = '0;
  logic [39:0] cfg_w_len = '0;
  logic [11:0] cfg_in_base = '0;
  logic [9:0]  cfg_in_len = '0;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [15:0] mem_rd_data = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_pe_sel;
  logic        out_is_filter;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic [3:0]  filter_finish;
  logic [3:0]  input_finish;

  always #5 clk = ~clk;

  pe_stream_responder dut (
    .clk(clk), .rst(rst),
    .req_filter_valid(req_filter_valid), .req_filter_k(req_filter_k),
    .req_layer(req_layer), .req_input_valid(req_input_valid),
    .cfg_w_base(cfg_w_base), .cfg_w_len(cfg_w_len),
    .cfg_in_base(cfg_in_base), .cfg_in_len(cfg_in_len),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_pe_sel(out_pe_sel),
    .out_is_filter(out_is_filter), .out_last(out_last), .out_ready(out_ready),
    .filter_finish(filter_finish), .input_finish(input_finish)
  );

  // SRAM model: each word tags its own address
  logic [15:0] mem [0:4095];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  typedef struct packed {
    logic        last;
    logic        is_filter;
    logic [3:0]  pe_sel;
    logic [15:0] data;
  } beat_t;

  typedef struct {
    int          pe;
    bit          isf;
    int          layer;
    int          k;
    logic [11:0] w_base;
    int          w_len;
    logic [11:0] in_base;
    int          in_len;
    logic [11:0] exp_addr;
    int          exp_len;
    int          exp_cycles;
    bit          toggle;
  } vec_t;

  beat_t sb[$];
  beat_t e;
  int    checks = 0;
  int    errors = 0;
  vec_t  vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int pe, input bit isf, input logic [11:0] addr, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.last      = (i == len - 1);
      b.is_filter = isf;
      b.pe_sel    = 4'(1 << pe);
      b.data      = {4'hA, 12'(addr + 12'(i))};
      sb.push_back(b);
    end
  endtask

  task automatic set_layer(input int l, input logic [11:0] base, input int len);
    cfg_w_base[l*12 +: 12] = base;
    cfg_w_len[l*10 +: 10]  = 10'(len);
  endtask

  // Beat monitor: pops on accept, checks hold of data/address on stall
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("beat_unexpected", 32'(sb.size()), 1);
      end else if (out_ready) begin
        e = sb.pop_front();
        check("beat", 32'({out_last, out_is_filter, out_pe_sel, out_data}), 32'(e));
      end else begin
        check("stall_hold", 32'({out_is_filter, out_pe_sel, out_data}),
              32'({sb[0].is_filter, sb[0].pe_sel, sb[0].data}));
        check("stall_addr", 32'(mem_rd_addr), 32'(sb[0].data[11:0]));
      end
    end
  end

  initial begin
    bit [0:8] pat;
    int       cyc, cin, cf;
    bit       done, dropped0, rearmed0;
    logic [3:0] prev_ff;
    int       order[$];
    int       exp_order[5];

    for (int a = 0; a < 4096; a++) mem[a] = {4'hA, 12'(a)};
    pat = 9'b111001101;
    exp_order = '{0, 1, 2, 3, 0};

    vecs[0] = '{0, 1'b1, 1, 2,  12'h100, 5,  12'h000, 0, 12'h10A, 5,  8,  1'b0};
    vecs[1] = '{2, 1'b0, 0, 0,  12'h000, 0,  12'h020, 3, 12'h020, 3,  6,  1'b0};
    vecs[2] = '{3, 1'b1, 2, 7,  12'h200, 0,  12'h000, 0, 12'h200, 0,  2,  1'b0};
    vecs[3] = '{1, 1'b1, 3, 0,  12'hFFE, 4,  12'h000, 0, 12'hFFE, 4,  7,  1'b0};
    vecs[4] = '{0, 1'b1, 0, 15, 12'hF00, 20, 12'h000, 0, 12'h02C, 20, 23, 1'b0};
    vecs[5] = '{1, 1'b0, 0, 0,  12'h000, 0,  12'h000, 4, 12'h000, 4,  0,  1'b1};

    // Reset state
    tick(); tick();
    check("reset_stream", 32'({out_valid, out_last, out_is_filter, out_pe_sel, out_data}), 0);
    check("reset_mem_fin", 32'({mem_rd_en, mem_rd_addr, filter_finish, input_finish}), 0);
    rst = 1'b0;
    tick();

    // Table-driven single transfers
    for (int v = 0; v < 6; v++) begin
      set_layer(vecs[v].layer, vecs[v].w_base, vecs[v].w_len);
      req_layer[vecs[v].pe*2 +: 2]    = 2'(vecs[v].layer);
      req_filter_k[vecs[v].pe*4 +: 4] = 4'(vecs[v].k);
      cfg_in_base = vecs[v].in_base;
      cfg_in_len  = 10'(vecs[v].in_len);
      push_beats(vecs[v].pe, vecs[v].isf, vecs[v].exp_addr, vecs[v].exp_len);
      out_ready = vecs[v].toggle ? pat[0] : 1'b1;
      if (vecs[v].isf) req_filter_valid[vecs[v].pe] = 1'b1;
      else             req_input_valid[vecs[v].pe]  = 1'b1;
      cyc = 0; done = 1'b0;
      for (int c = 1; c <= 200 && !done; c++) begin
        tick();
        cyc = c;
        out_ready = (vecs[v].toggle && c < 9) ? pat[c] : 1'b1;
        done = vecs[v].isf ? filter_finish[vecs[v].pe] : input_finish[vecs[v].pe];
      end
      check($sformatf("v%0d_finish_seen", v), 32'(done), 1);
      if (vecs[v].exp_cycles != 0) check($sformatf("v%0d_latency", v), 32'(cyc), 32'(vecs[v].exp_cycles));
      check($sformatf("v%0d_sb_drained", v), 32'(sb.size()), 0);
      check($sformatf("v%0d_finish_vec", v),
            32'({filter_finish, input_finish}),
            vecs[v].isf ? 32'({4'(1 << vecs[v].pe), 4'h0}) : 32'({4'h0, 4'(1 << vecs[v].pe)}));
      req_filter_valid = '0;
      req_input_valid  = '0;
      tick();
      check($sformatf("v%0d_finish_clear", v), 32'({filter_finish, input_finish}), 0);
      sb.delete();
    end

    // Input and filter on the same PE: input first
    set_layer(0, 12'h300, 2);
    req_layer[2 +: 2] = 2'd0;
    req_filter_k[4 +: 4] = 4'd1;
    cfg_in_base = 12'h000;
    cfg_in_len  = 10'd3;
    push_beats(1, 1'b0, 12'h000, 3);
    push_beats(1, 1'b1, 12'h302, 2);
    req_input_valid[1]  = 1'b1;
    req_filter_valid[1] = 1'b1;
    cin = 0; cf = 0;
    for (int c = 1; c <= 100 && cf == 0; c++) begin
      tick();
      if (cin == 0 && input_finish[1])  cin = c;
      if (cf == 0 && filter_finish[1])  cf = c;
    end
    check("both_input_finish_cycle", 32'(cin), 6);
    check("both_filter_finish_cycle", 32'(cf), 11);
    check("both_sb_drained", 32'(sb.size()), 0);
    req_input_valid = '0; req_filter_valid = '0;
    tick();
    check("both_finish_clear", 32'({filter_finish, input_finish}), 0);

    // Round robin from a fresh pointer, PE0 re-requests after its first transfer
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    sb.delete();
    set_layer(0, 12'h400, 2);
    req_layer = '0;
    for (int p = 0; p < 4; p++) begin
      req_filter_k[p*4 +: 4] = 4'(p);
      push_beats(p, 1'b1, 12'(12'h400 + 12'(2*p)), 2);
    end
    req_filter_valid = 4'hF;
    prev_ff = '0; dropped0 = 1'b0; rearmed0 = 1'b0;
    for (int c = 1; c <= 200 && order.size() < 5; c++) begin
      tick();
      for (int p = 0; p < 4; p++) if (filter_finish[p] && !prev_ff[p]) order.push_back(p);
      prev_ff = filter_finish;
      if (!dropped0 && filter_finish[0]) begin
        req_filter_valid[0] = 1'b0;
        dropped0 = 1'b1;
      end else if (dropped0 && !rearmed0 && !filter_finish[0]) begin
        req_filter_k[3:0] = 4'd5;
        push_beats(0, 1'b1, 12'h40A, 2);
        req_filter_valid[0] = 1'b1;
        rearmed0 = 1'b1;
      end
    end
    check("rr_count", 32'(order.size()), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    end
    check("rr_sb_drained", 32'(sb.size()), 0);
    req_filter_valid = '0;
    tick();
    check("rr_finish_clear", 32'({filter_finish, input_finish}), 0);

    // Reset on beat 2 of 6, then full re-service of the held request
    sb.delete();
    set_layer(0, 12'h500, 6);
    req_filter_k[8 +: 4] = 4'd0;
    push_beats(2, 1'b1, 12'h500, 6);
    req_filter_valid[2] = 1'b1;
    tick(); tick(); tick();
    check("rst_mid_beat2_valid", 32'({out_valid, out_data}), 32'({1'b1, 4'hA, 12'h501}));
    rst = 1'b1;
    tick();
    check("rst_mid_stream_zero", 32'({out_valid, out_last, out_is_filter, out_pe_sel, out_data}), 0);
    check("rst_mid_mem_fin_zero", 32'({mem_rd_en, mem_rd_addr, filter_finish, input_finish}), 0);
    sb.delete();
    push_beats(2, 1'b1, 12'h500, 6);
    rst = 1'b0;
    done = 1'b0;
    for (int c = 1; c <= 100 && !done; c++) begin
      tick();
      done = filter_finish[2];
    end
    check("rst_reserve_finish", 32'(done), 1);
    check("rst_reserve_sb_drained", 32'(sb.size()), 0);
    req_filter_valid = '0;
    tick();
    check("rst_reserve_clear", 32'({filter_finish, input_finish}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
